// File: rtl/tcam_fanout_router.sv
// TCAM routing table for the spike-routing path.
// A packet key is masked-matched against every valid entry; each hit is then
// streamed out lowest address first over a valid/ready handshake.
module tcam_fanout_router #(
   parameter int ID_Width      = 4,
   parameter int Axon_Width    = 2,
   parameter int Synapse_Width = 2,
   parameter int Weight_Width  = 4,
   parameter int Words         = 16,
   parameter int Bits          = ID_Width + Axon_Width + Synapse_Width,
   parameter int AddressSize   = $clog2(Words)
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    flush,
   input  logic                    cfg_we,
   output logic                    cfg_ready,
   input  logic [AddressSize-1:0]  cfg_addr,
   input  logic [Bits-1:0]         cfg_key,
   input  logic [Bits-1:0]         cfg_care,
   input  logic [ID_Width-1:0]     cfg_dst,
   input  logic [Weight_Width-1:0] cfg_weight,
   input  logic                    cfg_vld,
   input  logic                    pkt_valid,
   output logic                    pkt_ready,
   input  logic [Bits-1:0]         pkt_key,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [ID_Width-1:0]     out_dst,
   output logic [Weight_Width-1:0] out_weight,
   output logic [AddressSize-1:0]  out_addr,
   output logic                    out_last,
   output logic                    miss,
   output logic [AddressSize:0]    hit_cnt
);

   typedef enum logic {IDLE, SCAN} state_t;

   state_t                  state;
   logic                    vld_mem  [Words];
   logic [Bits-1:0]         key_mem  [Words];
   logic [Bits-1:0]         care_mem [Words];
   logic [ID_Width-1:0]     dst_mem  [Words];
   logic [Weight_Width-1:0] wt_mem   [Words];

   logic [Words-1:0]        match_vec;
   logic [Words-1:0]        hit_vec;
   logic [Words-1:0]        hit_rest;
   logic [AddressSize:0]    match_cnt;
   logic                    found;

   localparam logic [Words-1:0] HitOne = {{(Words-1){1'b0}}, 1'b1};

   assign cfg_ready = rst_n & (state == IDLE);
   assign pkt_ready = rst_n & (state == IDLE) & ~flush & ~cfg_we;
   assign hit_rest  = hit_vec & (hit_vec - HitOne);
   assign out_last  = (hit_vec != '0) && (hit_rest == '0);

   // Masked compare of the incoming key against every entry, plus hit popcount
   always_comb begin
      match_vec = '0;
      match_cnt = '0;
      for (int unsigned i = 0; i < Words; i++) begin
         match_vec[i] = vld_mem[i] & ~|((key_mem[i] ^ pkt_key) & care_mem[i]);
         match_cnt    = match_cnt + {{AddressSize{1'b0}}, match_vec[i]};
      end
   end

   // Present the payload of the lowest pending hit; zeros when nothing is pending
   always_comb begin
      found      = 1'b0;
      out_dst    = '0;
      out_weight = '0;
      out_addr   = '0;
      for (int unsigned i = 0; i < Words; i++) begin
         if (hit_vec[i] && !found) begin
            found      = 1'b1;
            out_dst    = dst_mem[i];
            out_weight = wt_mem[i];
            out_addr   = AddressSize'(i);
         end
      end
   end

   // Table storage: cleared by reset, valid bits dropped by flush, written only in IDLE
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned i = 0; i < Words; i++) begin
            vld_mem[i]  <= 1'b0;
            key_mem[i]  <= '0;
            care_mem[i] <= '0;
            dst_mem[i]  <= '0;
            wt_mem[i]   <= '0;
         end
      end else if (flush) begin
         for (int unsigned i = 0; i < Words; i++) begin
            vld_mem[i] <= 1'b0;
         end
      end else if (cfg_we && cfg_ready) begin
         // Addresses at or beyond Words match no loop index and are dropped
         for (int unsigned i = 0; i < Words; i++) begin
            if (cfg_addr == AddressSize'(i)) begin
               vld_mem[i]  <= cfg_vld;
               key_mem[i]  <= cfg_key;
               care_mem[i] <= cfg_care;
               dst_mem[i]  <= cfg_dst;
               wt_mem[i]   <= cfg_weight;
            end
         end
      end
   end

   // Lookup FSM: snapshot hits on accept, then retire one hit per handshake
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         hit_vec   <= '0;
         out_valid <= 1'b0;
         miss      <= 1'b0;
         hit_cnt   <= '0;
      end else begin
         miss <= 1'b0;
         if (flush) begin
            state     <= IDLE;
            hit_vec   <= '0;
            out_valid <= 1'b0;
         end else begin
            case (state)
               IDLE: begin
                  if (pkt_valid && pkt_ready) begin
                     hit_cnt <= match_cnt;
                     if (match_vec == '0) begin
                        miss <= 1'b1;
                     end else begin
                        hit_vec   <= match_vec;
                        out_valid <= 1'b1;
                        state     <= SCAN;
                     end
                  end
               end
               SCAN: begin
                  if (out_ready) begin
                     hit_vec <= hit_rest;
                     if (out_last) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                     end
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_tcam_fanout_router.sv
// Directed bench for tcam_fanout_router: inputs driven and outputs sampled on the falling edge.
module tb_tcam_fanout_router;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       flush;
   logic       cfg_we;
   logic       cfg_ready;
   logic [3:0] cfg_addr;
   logic [7:0] cfg_key;
   logic [7:0] cfg_care;
   logic [3:0] cfg_dst;
   logic [3:0] cfg_weight;
   logic       cfg_vld;
   logic       pkt_valid;
   logic       pkt_ready;
   logic [7:0] pkt_key;
   logic       out_valid;
   logic       out_ready;
   logic [3:0] out_dst;
   logic [3:0] out_weight;
   logic [3:0] out_addr;
   logic       out_last;
   logic       miss;
   logic [4:0] hit_cnt;

   int vectors = 0;
   int errors  = 0;

   always #5 clk = ~clk;

   tcam_fanout_router #(
      .ID_Width(4), .Axon_Width(2), .Synapse_Width(2), .Weight_Width(4), .Words(16)
   ) dut (
      .clk(clk), .rst_n(rst_n), .flush(flush),
      .cfg_we(cfg_we), .cfg_ready(cfg_ready), .cfg_addr(cfg_addr), .cfg_key(cfg_key),
      .cfg_care(cfg_care), .cfg_dst(cfg_dst), .cfg_weight(cfg_weight), .cfg_vld(cfg_vld),
      .pkt_valid(pkt_valid), .pkt_ready(pkt_ready), .pkt_key(pkt_key),
      .out_valid(out_valid), .out_ready(out_ready), .out_dst(out_dst), .out_weight(out_weight),
      .out_addr(out_addr), .out_last(out_last), .miss(miss), .hit_cnt(hit_cnt)
   );

   task automatic write_entry(input logic [3:0] a, input logic [7:0] k, input logic [7:0] c,
                              input logic [3:0] d, input logic [3:0] w, input logic v);
      @(negedge clk);
      cfg_we = 1'b1; cfg_addr = a; cfg_key = k; cfg_care = c;
      cfg_dst = d; cfg_weight = w; cfg_vld = v;
      @(negedge clk);
      cfg_we = 1'b0;
   endtask

   // Presents a packet for exactly one rising edge; returns on the falling edge after accept
   task automatic send_pkt(input logic [7:0] k);
      @(negedge clk);
      pkt_valid = 1'b1; pkt_key = k;
      @(negedge clk);
      pkt_valid = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; flush = 1'b0; cfg_we = 1'b0; cfg_addr = '0; cfg_key = '0; cfg_care = '0;
      cfg_dst = '0; cfg_weight = '0; cfg_vld = 1'b0; pkt_valid = 1'b0; pkt_key = '0; out_ready = 1'b1;
      repeat (2) @(negedge clk);
      vectors++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
      vectors++; if (miss !== 1'b0) begin errors++; $display("FAIL reset_miss got %b want 0", miss); end
      vectors++; if (hit_cnt !== 5'd0) begin errors++; $display("FAIL reset_hit_cnt got %0d want 0", hit_cnt); end
      vectors++; if ({out_dst, out_weight, out_addr, out_last} !== 13'd0) begin errors++;
         $display("FAIL reset_out_fields got %h want 0", {out_dst, out_weight, out_addr, out_last}); end
      vectors++; if ({cfg_ready, pkt_ready} !== 2'b00) begin errors++;
         $display("FAIL reset_readies got %b want 00", {cfg_ready, pkt_ready}); end
      rst_n = 1'b1;
      @(negedge clk);
      vectors++; if ({cfg_ready, pkt_ready} !== 2'b11) begin errors++;
         $display("FAIL idle_readies got %b want 11", {cfg_ready, pkt_ready}); end
   endtask

   task automatic test_single_hit();
      write_entry(4'd0, 8'h12, 8'hFF, 4'd3, 4'd5, 1'b1);
      send_pkt(8'h12);
      vectors++; if ({out_valid, out_dst, out_weight, out_addr, out_last} !== {1'b1, 4'd3, 4'd5, 4'd0, 1'b1}) begin
         errors++; $display("FAIL single_hit got v%b d%0d w%0d a%0d l%b want v1 d3 w5 a0 l1",
                            out_valid, out_dst, out_weight, out_addr, out_last); end
      vectors++; if (hit_cnt !== 5'd1) begin errors++; $display("FAIL single_hit_cnt got %0d want 1", hit_cnt); end
      @(negedge clk);
      vectors++; if ({out_valid, pkt_ready} !== 2'b01) begin errors++;
         $display("FAIL single_done got valid/ready %b want 01", {out_valid, pkt_ready}); end
   endtask

   task automatic test_fanout();
      logic [3:0] exp_addr [3];
      exp_addr = '{4'd2, 4'd5, 4'd9};
      write_entry(4'd2, 8'h40, 8'hF0, 4'd2, 4'd13, 1'b1);
      write_entry(4'd5, 8'h40, 8'hF0, 4'd5, 4'd10, 1'b1);
      write_entry(4'd9, 8'h40, 8'hF0, 4'd9, 4'd6, 1'b1);
      out_ready = 1'b1;
      send_pkt(8'h47);
      vectors++; if (hit_cnt !== 5'd3) begin errors++; $display("FAIL fanout_hit_cnt got %0d want 3", hit_cnt); end
      vectors++; if ({cfg_ready, pkt_ready} !== 2'b00) begin errors++;
         $display("FAIL scan_readies got %b want 00", {cfg_ready, pkt_ready}); end
      for (int k = 0; k < 3; k++) begin
         vectors++;
         if ({out_valid, out_addr, out_dst, out_weight, out_last} !==
             {1'b1, exp_addr[k], exp_addr[k], 4'd15 - exp_addr[k], (k == 2)}) begin
            errors++; $display("FAIL fanout_hit%0d got v%b a%0d d%0d w%0d l%b want a%0d last %0d", k,
                               out_valid, out_addr, out_dst, out_weight, out_last, exp_addr[k], (k == 2));
         end
         @(negedge clk);
      end
      vectors++; if ({out_valid, pkt_ready} !== 2'b01) begin errors++;
         $display("FAIL fanout_done got valid/ready %b want 01", {out_valid, pkt_ready}); end
   endtask

   task automatic test_stall();
      out_ready = 1'b1;
      send_pkt(8'h47);
      vectors++; if (out_addr !== 4'd2) begin errors++; $display("FAIL stall_first got a%0d want 2", out_addr); end
      @(negedge clk);
      out_ready = 1'b0;
      vectors++; if (out_addr !== 4'd5) begin errors++; $display("FAIL stall_second got a%0d want 5", out_addr); end
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         vectors++;
         if ({out_valid, out_addr, out_dst, out_weight, out_last} !== {1'b1, 4'd5, 4'd5, 4'd10, 1'b0}) begin
            errors++; $display("FAIL stall_hold%0d got v%b a%0d d%0d w%0d l%b want v1 a5 d5 w10 l0", k,
                               out_valid, out_addr, out_dst, out_weight, out_last);
         end
      end
      out_ready = 1'b1;
      @(negedge clk);
      vectors++; if ({out_valid, out_addr, out_last} !== {1'b1, 4'd9, 1'b1}) begin errors++;
         $display("FAIL stall_resume got v%b a%0d l%b want v1 a9 l1", out_valid, out_addr, out_last); end
      @(negedge clk);
      vectors++; if (out_valid !== 1'b0) begin errors++; $display("FAIL stall_done got %b want 0", out_valid); end
   endtask

   task automatic test_miss();
      send_pkt(8'hAA);
      vectors++; if ({miss, out_valid, pkt_ready, hit_cnt} !== {3'b101, 5'd0}) begin errors++;
         $display("FAIL miss_pulse got m%b v%b r%b c%0d want m1 v0 r1 c0", miss, out_valid, pkt_ready, hit_cnt); end
      @(negedge clk);
      vectors++; if ({miss, out_valid} !== 2'b00) begin errors++;
         $display("FAIL miss_width got m%b v%b want 00", miss, out_valid); end
   endtask

   task automatic test_flush();
      out_ready = 1'b1;
      send_pkt(8'h47);
      @(negedge clk);
      vectors++; if (out_addr !== 4'd5) begin errors++; $display("FAIL flush_pre got a%0d want 5", out_addr); end
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      #1;
      vectors++; if ({out_valid, miss, pkt_ready, hit_cnt} !== {3'b001, 5'd3}) begin errors++;
         $display("FAIL flush_abort got v%b m%b r%b c%0d want v0 m0 r1 c3", out_valid, miss, pkt_ready, hit_cnt); end
      send_pkt(8'h47);
      vectors++; if ({miss, out_valid, hit_cnt} !== {2'b10, 5'd0}) begin errors++;
         $display("FAIL flush_resend got m%b v%b c%0d want m1 v0 c0", miss, out_valid, hit_cnt); end
   endtask

   task automatic test_write_wins();
      @(negedge clk);
      cfg_we = 1'b1; cfg_addr = 4'd7; cfg_key = 8'h47; cfg_care = 8'hFF;
      cfg_dst = 4'hA; cfg_weight = 4'h6; cfg_vld = 1'b1;
      pkt_valid = 1'b1; pkt_key = 8'h47;
      #1;
      vectors++; if ({cfg_ready, pkt_ready} !== 2'b10) begin errors++;
         $display("FAIL collide_readies got %b want 10", {cfg_ready, pkt_ready}); end
      @(negedge clk);
      cfg_we = 1'b0;
      #1;
      vectors++; if (pkt_ready !== 1'b1) begin errors++; $display("FAIL collide_retry got %b want 1", pkt_ready); end
      @(negedge clk);
      pkt_valid = 1'b0;
      vectors++; if ({out_valid, out_addr, out_dst, out_weight, out_last, hit_cnt} !==
                     {1'b1, 4'd7, 4'hA, 4'h6, 1'b1, 5'd1}) begin errors++;
         $display("FAIL collide_hit got v%b a%0d d%0d w%0d l%b c%0d want v1 a7 d10 w6 l1 c1",
                  out_valid, out_addr, out_dst, out_weight, out_last, hit_cnt); end
      @(negedge clk);
   endtask

   task automatic test_boundary();
      write_entry(4'd15, 8'h00, 8'h00, 4'hF, 4'hE, 1'b1);
      write_entry(4'd3, 8'h33, 8'hFF, 4'h1, 4'h1, 1'b0);
      send_pkt(8'h33);
      vectors++; if ({out_valid, out_addr, out_dst, out_weight, out_last, hit_cnt} !==
                     {1'b1, 4'd15, 4'hF, 4'hE, 1'b1, 5'd1}) begin errors++;
         $display("FAIL dontcare_top got v%b a%0d d%0d w%0d l%b c%0d want v1 a15 d15 w14 l1 c1",
                  out_valid, out_addr, out_dst, out_weight, out_last, hit_cnt); end
      @(negedge clk);
      send_pkt(8'h47);
      vectors++; if ({out_addr, out_last, hit_cnt} !== {4'd7, 1'b0, 5'd2}) begin errors++;
         $display("FAIL two_hits_first got a%0d l%b c%0d want a7 l0 c2", out_addr, out_last, hit_cnt); end
      @(negedge clk);
      vectors++; if ({out_addr, out_last} !== {4'd15, 1'b1}) begin errors++;
         $display("FAIL two_hits_second got a%0d l%b want a15 l1", out_addr, out_last); end
      @(negedge clk);
   endtask

   task automatic test_reset_midscan();
      out_ready = 1'b0;
      send_pkt(8'h47);
      vectors++; if (out_valid !== 1'b1) begin errors++; $display("FAIL midscan_start got %b want 1", out_valid); end
      rst_n = 1'b0;
      #1;
      vectors++; if ({out_valid, cfg_ready, pkt_ready} !== 3'b000) begin errors++;
         $display("FAIL midscan_abort got %b want 000", {out_valid, cfg_ready, pkt_ready}); end
      @(negedge clk);
      rst_n = 1'b1;
      out_ready = 1'b1;
      send_pkt(8'h47);
      vectors++; if ({miss, out_valid, hit_cnt} !== {2'b10, 5'd0}) begin errors++;
         $display("FAIL midscan_cleared got m%b v%b c%0d want m1 v0 c0", miss, out_valid, hit_cnt); end
   endtask

   initial begin
      test_reset();
      test_single_hit();
      test_fanout();
      test_stall();
      test_miss();
      test_flush();
      test_write_wins();
      test_boundary();
      test_reset_midscan();
      repeat (2) @(negedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
